hazard_controller: RTL

Pipeline hazard and sequencing controller for the five-stage core (IF, ID, EX, MEM, WB). It sits beside the opcode decoder and consumes the decoded control of the ID-stage instruction, including its jump type, register write and memory read flags. It tracks in-flight destination registers in a three-slot scoreboard. From that it drives stall, flush and forwarding-select signals for the datapath, plus two saturating performance counters.

---
 rtl/hazard_pkg.sv | 43 ++++
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_controller.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: FSM states, forwarding selects,
// the scoreboard slot record and the forwarding-select helper.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  jump;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // The younger producer (MEM) wins; r0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_select(input slot_t mem_s, input slot_t wb_s,
                                            input logic [REG_ADDR_W-1:0] src);
    if (mem_s.valid && mem_s.reg_write && (mem_s.rd != '0) && (mem_s.rd == src))
      return FWD_MEM;
    else if (wb_s.valid && wb_s.reg_write && (wb_s.rd != '0) && (wb_s.rd == src))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Stall / flush / forwarding control for the five-stage core, driven by a
// three-slot (EX, MEM, WB) scoreboard of in-flight instructions.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic [2:0]            id_jump_type_i,
  input  logic                  ex_taken_i,
  input  logic                  mem_busy_i,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  freeze_o,
  output logic                  flush_if_o,
  output logic                  flush_id_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      flush_events_o
);

  hz_state_e  state_q, state_d;
  slot_t      ex_q, mem_q, wb_q;
  slot_t      id_slot;
  logic       br_taken, load_use, issue;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic       unused_slot_bits;

  assign br_taken = ex_q.valid & ex_q.jump & ex_taken_i;
  assign load_use = id_valid_i & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                    ((id_use_rs1_i & (id_rs1_i == ex_q.rd)) |
                     (id_use_rs2_i & (id_rs2_i == ex_q.rd)));

  always_comb begin
    state_d    = state_q;
    stall_if_o = 1'b0;
    stall_id_o = 1'b0;
    freeze_o   = 1'b0;
    flush_if_o = 1'b0;
    flush_id_o = 1'b0;
    fwd_a_o    = FWD_REG;
    fwd_b_o    = FWD_REG;
    if (!rst_ni) begin
      state_d = RUN;
    end else begin
      fwd_a_o = fwd_select(mem_q, wb_q, ex_q.rs1);
      fwd_b_o = fwd_select(mem_q, wb_q, ex_q.rs2);
      if (mem_busy_i) begin
        freeze_o   = 1'b1;
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        state_d    = MEM_WAIT;
      end else begin
        case (state_q)
          // Leaving MEM_WAIT re-evaluates exactly as RUN would this cycle.
          RUN, MEM_WAIT: begin
            if (br_taken) begin
              flush_if_o = 1'b1;
              flush_id_o = 1'b1;
              state_d    = BR_FLUSH;
            end else if (load_use) begin
              stall_if_o = 1'b1;
              stall_id_o = 1'b1;
              state_d    = LD_STALL;
            end else begin
              state_d = RUN;
            end
          end
          default: state_d = RUN;
        endcase
      end
    end
  end

  assign issue = id_valid_i & ~stall_id_o & ~flush_id_o;

  always_comb begin
    id_slot           = SLOT_BUBBLE;
    id_slot.valid     = 1'b1;
    id_slot.rd        = id_rd_i;
    id_slot.reg_write = id_reg_write_i;
    id_slot.mem_read  = id_mem_read_i;
    id_slot.jump      = (id_jump_type_i != 3'd0);
    id_slot.rs1       = id_rs1_i;
    id_slot.rs2       = id_rs2_i;
    id_slot.use_rs1   = id_use_rs1_i;
    id_slot.use_rs2   = id_use_rs2_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
      ex_q    <= SLOT_BUBBLE;
      mem_q   <= SLOT_BUBBLE;
      wb_q    <= SLOT_BUBBLE;
    end else begin
      state_q <= state_d;
      if (!freeze_o) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= issue ? id_slot : SLOT_BUBBLE;
      end
    end
  end

  // Some slot fields are carried only for debug visibility.
  assign unused_slot_bits = ^{ex_q, mem_q, wb_q};

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (stall_id_o),
    .count_o (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (flush_if_o),
    .count_o (flush_cnt)
  );

  assign stall_cycles_o = rst_ni ? stall_cnt : '0;
  assign flush_events_o = rst_ni ? flush_cnt : '0;

endmodule
